// File: rtl/complex_div_arbiter_if.sv
// rtl/complex_div_arbiter_if.sv - requester, response and divider-side bundle for complex_div_arbiter
interface complex_div_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 64,
    parameter int MAX_INFLIGHT = 8
);
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    logic                                flush_i;
    logic [NUM_REQ-1:0]                  req_valid_i;
    logic [NUM_REQ-1:0]                  req_ready_o;
    logic [NUM_REQ-1:0][4*WIDTH-1:0]     req_operands_i;
    logic [NUM_REQ-1:0]                  resp_valid_o;
    logic [NUM_REQ-1:0]                  resp_ready_i;
    logic [2*WIDTH-1:0]                  resp_result_o;
    logic [4:0]                          resp_status_o;
    logic                                div_valid_o;
    logic                                div_ready_i;
    logic [4*WIDTH-1:0]                  div_operands_o;
    logic                                div_flush_o;
    logic                                div_out_valid_i;
    logic                                div_out_ready_o;
    logic [2*WIDTH-1:0]                  div_result_i;
    logic [4:0]                          div_status_i;
    logic [CW-1:0]                       inflight_o;
    logic                                busy_o;

    // Arbiter view
    modport slave (
        input  flush_i, req_valid_i, req_operands_i, resp_ready_i,
               div_ready_i, div_out_valid_i, div_result_i, div_status_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_status_o,
               div_valid_o, div_operands_o, div_flush_o, div_out_ready_o,
               inflight_o, busy_o
    );

    // Environment view: requesters plus divider
    modport master (
        output flush_i, req_valid_i, req_operands_i, resp_ready_i,
               div_ready_i, div_out_valid_i, div_result_i, div_status_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_status_o,
               div_valid_o, div_operands_o, div_flush_o, div_out_ready_o,
               inflight_o, busy_o
    );
endinterface

// File: rtl/complex_div_arbiter.sv
// rtl/complex_div_arbiter.sv - round-robin sharing of one in-order complex divider with ID-steered results
module complex_div_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 64,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    complex_div_arbiter_if.slave bus
);
    localparam int PW  = $clog2(MAX_INFLIGHT);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ID FIFO: one entry per outstanding divide, extra pointer bit separates full from empty
    logic [IDW-1:0] id_mem [MAX_INFLIGHT];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;

    logic [IDW-1:0] rr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] head;
    logic           any_req;
    logic           fifo_empty;
    logic           fifo_full;
    logic           can_issue;
    logic           issue_fire;
    logic           ret_fire;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head       = id_mem[rd_ptr[PW-1:0]];

    // Round-robin search: first valid requester at or after rr, wrapping
    always_comb begin
        int             idx;
        logic           found;
        logic [IDW-1:0] sel;
        idx     = 0;
        found   = 1'b0;
        sel     = '0;
        grant   = rr;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDW'(idx);
            if (!found && bus.req_valid_i[sel]) begin
                found   = 1'b1;
                any_req = 1'b1;
                grant   = sel;
            end
        end
    end

    assign rr_next = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    // Reset gates the handshakes combinationally so an asserted rst_i quiets the bus at once
    assign can_issue = bus.div_ready_i & ~fifo_full & ~bus.flush_i & ~rst_i;

    // Issue side: grant is passed straight through to the divider, no operand register
    always_comb begin
        bus.req_ready_o    = '0;
        bus.div_valid_o    = can_issue & any_req;
        bus.div_operands_o = '0;
        if (any_req && !rst_i) begin
            bus.div_operands_o = bus.req_operands_i[grant];
        end
        if (bus.div_valid_o) begin
            bus.req_ready_o[grant] = 1'b1;
        end
    end

    // Return side: steer the divider output to the requester at the FIFO head
    always_comb begin
        bus.resp_valid_o    = '0;
        bus.div_out_ready_o = 1'b0;
        if (!fifo_empty && !bus.flush_i && !rst_i) begin
            bus.resp_valid_o[head] = bus.div_out_valid_i;
            bus.div_out_ready_o    = bus.resp_ready_i[head];
        end
    end

    assign issue_fire = bus.div_valid_o & bus.div_ready_i;
    assign ret_fire   = bus.div_out_valid_i & bus.div_out_ready_o;

    assign bus.resp_result_o = bus.div_result_i;
    assign bus.resp_status_o = bus.div_status_i;
    assign bus.div_flush_o   = bus.flush_i;
    assign bus.inflight_o    = wr_ptr - rd_ptr;
    assign bus.busy_o        = (bus.inflight_o != '0);

    // Pointers and round-robin state; flush empties the FIFO but keeps rr
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr     <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (issue_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr     <= rr_next;
            end
            if (ret_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ID storage; entries are only read while the FIFO is non-empty, so no reset needed
    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            id_mem[wr_ptr[PW-1:0]] <= grant;
        end
    end

    // A result with nothing outstanding means the divider broke the in-order contract
    a_no_orphan_result: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.div_out_valid_i && fifo_empty));

endmodule

// File: tb/tb_complex_div_arbiter.sv
// tb/tb_complex_div_arbiter.sv - directed self-checking bench for complex_div_arbiter
module tb_complex_div_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;

    complex_div_arbiter_if #(.NUM_REQ(4), .WIDTH(64), .MAX_INFLIGHT(8)) bus ();

    complex_div_arbiter #(.NUM_REQ(4), .WIDTH(64), .MAX_INFLIGHT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [255:0] op_a2;
    logic [127:0] res_a2;
    int           rr_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int           drain_order [4] = '{2, 3, 0, 1};

    initial begin
        bus.flush_i         = 1'b0;
        bus.req_valid_i     = 4'b1111;
        bus.req_operands_i  = '0;
        bus.resp_ready_i    = 4'b0000;
        bus.div_ready_i     = 1'b1;
        bus.div_out_valid_i = 1'b0;
        bus.div_result_i    = '0;
        bus.div_status_i    = '0;
        // (7+j2)/(1+j2) = (11-j12)/5 = 2.2 - j2.4
        op_a2  = {$realtobits(2.0), $realtobits(1.0), $realtobits(2.0), $realtobits(7.0)};
        res_a2 = {$realtobits(-2.4), $realtobits(2.2)};

        // Reset state with requests pending
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready_o, 4'b0000);
        chk("rst_div_valid", bus.div_valid_o, 1'b0);
        chk("rst_inflight", bus.inflight_o, 4'd0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_operands", bus.div_operands_o, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = 4'b0000;

        // Single request from requester 2
        @(negedge clk);
        bus.req_valid_i       = 4'b0100;
        bus.req_operands_i[2] = op_a2;
        #1;
        chk("single_req_ready", bus.req_ready_o, 4'b0100);
        chk("single_div_valid", bus.div_valid_o, 1'b1);
        chk("single_operands", bus.div_operands_o, op_a2);
        @(negedge clk);
        bus.req_valid_i     = 4'b0000;
        bus.div_out_valid_i = 1'b1;
        bus.div_result_i    = res_a2;
        bus.div_status_i    = 5'b00001;
        bus.resp_ready_i    = 4'b0100;
        #1;
        chk("single_inflight1", bus.inflight_o, 4'd1);
        chk("single_busy1", bus.busy_o, 1'b1);
        chk("single_resp_valid", bus.resp_valid_o, 4'b0100);
        chk("single_out_ready", bus.div_out_ready_o, 1'b1);
        chk("single_result", bus.resp_result_o, {$realtobits(-2.4), $realtobits(2.2)});
        chk("single_status", bus.resp_status_o, 5'b00001);
        @(negedge clk);
        bus.div_out_valid_i = 1'b0;
        bus.resp_ready_i    = 4'b0000;
        #1;
        chk("single_inflight0", bus.inflight_o, 4'd0);
        chk("single_busy0", bus.busy_o, 1'b0);

        // Return rr to 0 before the fairness run
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_operands_i[i] = 256'(100 + i);
        end

        // Round-robin with all requesters valid, divider never returning: fills the FIFO
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req_valid_i = 4'b1111;
            #1;
            chk($sformatf("rr_grant%0d", k), bus.req_ready_o, 4'b0001 << rr_order[k]);
            chk($sformatf("rr_operands%0d", k), bus.div_operands_o, 256'(100 + rr_order[k]));
        end
        @(negedge clk);
        #1;
        chk("full_inflight8", bus.inflight_o, 4'd8);
        chk("full_req_ready", bus.req_ready_o, 4'b0000);
        chk("full_div_valid", bus.div_valid_o, 1'b0);
        bus.div_out_valid_i = 1'b1;
        bus.resp_ready_i    = 4'b0001;
        #1;
        chk("full_pop_resp_valid", bus.resp_valid_o, 4'b0001);
        chk("full_pop_out_ready", bus.div_out_ready_o, 1'b1);
        chk("full_pop_no_issue", bus.req_ready_o, 4'b0000);
        @(negedge clk);
        bus.div_out_valid_i = 1'b0;
        bus.resp_ready_i    = 4'b0000;
        #1;
        chk("after_pop_inflight7", bus.inflight_o, 4'd7);
        chk("after_pop_one_issue", bus.req_ready_o, 4'b0001);
        @(negedge clk);
        bus.req_valid_i = 4'b0000;
        #1;
        chk("refull_inflight8", bus.inflight_o, 4'd8);

        // Return stall: head requester 1 not ready for 5 cycles
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            bus.div_out_valid_i = 1'b1;
            bus.resp_ready_i    = 4'b0000;
            #1;
            chk($sformatf("stall_out_ready%0d", s), bus.div_out_ready_o, 1'b0);
            chk($sformatf("stall_resp_valid%0d", s), bus.resp_valid_o, 4'b0010);
            chk($sformatf("stall_inflight%0d", s), bus.inflight_o, 4'd8);
        end
        @(negedge clk);
        bus.resp_ready_i = 4'b0010;
        #1;
        chk("stall_release_ready", bus.div_out_ready_o, 1'b1);
        @(negedge clk);
        bus.resp_ready_i = 4'b0000;
        #1;
        chk("stall_popped_inflight", bus.inflight_o, 4'd7);
        chk("stall_next_head", bus.resp_valid_o, 4'b0100);

        // Drain down to 3 outstanding, checking issue order
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            bus.div_out_valid_i = 1'b1;
            bus.resp_ready_i    = 4'b1111;
            #1;
            chk($sformatf("drain_head%0d", d), bus.resp_valid_o, 4'b0001 << drain_order[d]);
        end

        // Simultaneous issue and return at 3 outstanding
        @(negedge clk);
        bus.req_valid_i = 4'b0010;
        #1;
        chk("simul_inflight_before", bus.inflight_o, 4'd3);
        chk("simul_req_ready", bus.req_ready_o, 4'b0010);
        chk("simul_resp_valid", bus.resp_valid_o, 4'b0100);
        chk("simul_out_ready", bus.div_out_ready_o, 1'b1);
        @(negedge clk);
        bus.req_valid_i = 4'b0000;
        #1;
        chk("simul_inflight_after", bus.inflight_o, 4'd3);
        chk("simul_order0", bus.resp_valid_o, 4'b1000);
        @(negedge clk);
        #1;
        chk("simul_order1", bus.resp_valid_o, 4'b0001);
        @(negedge clk);
        #1;
        chk("simul_order2", bus.resp_valid_o, 4'b0010);
        @(negedge clk);
        bus.div_out_valid_i = 1'b0;
        bus.resp_ready_i    = 4'b0000;
        #1;
        chk("simul_drained", bus.inflight_o, 4'd0);

        // rr = 2 with only requesters 0 and 3 valid
        @(negedge clk);
        bus.req_valid_i = 4'b1001;
        #1;
        chk("rr2_first", bus.req_ready_o, 4'b1000);
        @(negedge clk);
        #1;
        chk("rr2_second", bus.req_ready_o, 4'b0001);
        @(negedge clk);
        bus.req_valid_i = 4'b1111;
        #1;
        chk("pre_flush_grant", bus.req_ready_o, 4'b0010);
        @(negedge clk);
        bus.req_valid_i = 4'b0000;
        #1;
        chk("pre_flush_inflight", bus.inflight_o, 4'd3);

        // Flush with 3 outstanding
        @(negedge clk);
        bus.flush_i         = 1'b1;
        bus.req_valid_i     = 4'b1111;
        bus.div_out_valid_i = 1'b1;
        bus.resp_ready_i    = 4'b1111;
        #1;
        chk("flush_div_flush", bus.div_flush_o, 1'b1);
        chk("flush_req_ready", bus.req_ready_o, 4'b0000);
        chk("flush_div_valid", bus.div_valid_o, 1'b0);
        chk("flush_resp_valid", bus.resp_valid_o, 4'b0000);
        chk("flush_out_ready", bus.div_out_ready_o, 1'b0);
        @(negedge clk);
        bus.flush_i         = 1'b0;
        bus.req_valid_i     = 4'b0000;
        bus.div_out_valid_i = 1'b0;
        bus.resp_ready_i    = 4'b0000;
        #1;
        chk("post_flush_inflight", bus.inflight_o, 4'd0);
        chk("post_flush_busy", bus.busy_o, 1'b0);
        chk("post_flush_div_flush", bus.div_flush_o, 1'b0);

        // rr kept across flush, then reset mid-burst
        @(negedge clk);
        bus.req_valid_i = 4'b1111;
        #1;
        chk("flush_rr_kept", bus.req_ready_o, 4'b0100);
        @(negedge clk);
        #1;
        chk("burst_grant", bus.req_ready_o, 4'b1000);
        chk("burst_inflight", bus.inflight_o, 4'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", bus.req_ready_o, 4'b0000);
        chk("midrst_div_valid", bus.div_valid_o, 1'b0);
        chk("midrst_inflight", bus.inflight_o, 4'd0);
        chk("midrst_busy", bus.busy_o, 1'b0);
        chk("midrst_operands", bus.div_operands_o, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = 4'b0000;
        #1;
        chk("after_rst_inflight", bus.inflight_o, 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
